// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM state encoding, byte-enable constants, wait-state limit
// and the byte-enable to bit-mask expansion used for read-lane masking.
package lsu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_t;

    localparam logic [3:0] BE_NONE  = 4'b0000;
    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam int         WAIT_MAX = 15;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/u_dmem.sv
// DEPTH x 32-bit single-port RAM with per-byte write enables and registered read.
// One-cycle latency: data read at the edge appears on rd the following cycle.
module u_dmem #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wd,
    output logic [31:0]              rd
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wd[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rd_q <= mem_q[addr];
            end
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/u_lsu.sv
// Load/store unit: WAIT wait states then one RAM access; lsu_vld pulses WAIT+1 cycles after accept.
// lsu_busy stalls the requester until the access cycle; LSU_MISALIGN_CHK_EN enables misalignment errors.
module u_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] lsu_a,
    input  logic [3:0]  lsu_we,
    input  logic [31:0] lsu_wd,
    input  logic [3:0]  lsu_re,
    output logic        lsu_vld,
    output logic [31:0] lsu_rd,
    output logic        lsu_busy,
    output logic        lsu_err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_C  = 4'(WAIT);
    localparam bit         NO_WAIT = (WAIT == 0);

    lsu_state_t     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [3:0]     we_q, we_d;
    logic [3:0]     re_q, re_d;
    logic [31:0]    wd_q, wd_d;
    logic           mis_q, mis_d;
    logic           vld_q, vld_d;
    logic           err_q, err_d;
    logic [31:0]    mask_q, mask_d;

    logic           req;
    logic           in_mis;
    logic           fire;
    logic           go;
    logic [AW-1:0]  f_idx;
    logic [3:0]     f_we;
    logic [3:0]     f_re;
    logic [31:0]    f_wd;
    logic           f_mis;
    logic [3:0]     mem_we;
    logic [31:0]    mem_rd;
    logic           unused_addr;

    assign req         = (lsu_we != BE_NONE) || (lsu_re != BE_NONE);
    assign unused_addr = ^{lsu_a[31:AW+2], lsu_a[1:0]};

`ifdef LSU_MISALIGN_CHK_EN
    assign in_mis = (lsu_a[1:0] != 2'b00);
`else
    assign in_mis = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        re_d    = re_q;
        wd_d    = wd_q;
        mis_d   = mis_q;
        fire    = 1'b0;
        f_idx   = lsu_a[AW+1:2];
        f_we    = lsu_we;
        f_re    = lsu_re;
        f_wd    = lsu_wd;
        f_mis   = in_mis;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (NO_WAIT) begin
                        fire = 1'b1;
                    end else begin
                        idx_d   = lsu_a[AW+1:2];
                        we_d    = lsu_we;
                        re_d    = lsu_re;
                        wd_d    = lsu_wd;
                        mis_d   = in_mis;
                        state_d = ST_BUSY;
                        cnt_d   = 4'd1;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == WAIT_C) begin
                    fire    = 1'b1;
                    f_idx   = idx_q;
                    f_we    = we_q;
                    f_re    = re_q;
                    f_wd    = wd_q;
                    f_mis   = mis_q;
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An access coinciding with reset must not touch the RAM.
        go     = fire & rstn;
        mem_we = (go && f_we != BE_NONE && !f_mis) ? f_we : BE_NONE;
        vld_d  = go;
        err_d  = go & f_mis;
        mask_d = (go && f_we == BE_NONE && !f_mis) ? be_to_mask(f_re) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= BE_NONE;
            re_q    <= BE_NONE;
            wd_q    <= '0;
            mis_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            re_q    <= re_d;
            wd_q    <= wd_d;
            mis_q   <= mis_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    u_dmem #(
        .DEPTH(DEPTH)
    ) u_dmem_i (
        .clk  (clk),
        .en   (go),
        .we   (mem_we),
        .addr (f_idx),
        .wd   (f_wd),
        .rd   (mem_rd)
    );

    // Busy is raised combinationally in the accept cycle so the requester holds its inputs.
    assign lsu_busy = rstn && !NO_WAIT &&
                      (((state_q == ST_IDLE) && req) ||
                       ((state_q == ST_BUSY) && (cnt_q != WAIT_C)));
    assign lsu_vld  = vld_q;
    assign lsu_err  = err_q;
    assign lsu_rd   = mem_rd & mask_q;

endmodule

// File: tb/tb_u_lsu.sv
// Randomized bench for u_lsu: a WAIT=0/DEPTH=1024 and a WAIT=3/DEPTH=64 instance
// checked against a word-array reference model of the load/store rules.
module tb_u_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rstn0, rstn3;
    logic [31:0] d0_a, d0_wd, d0_rd, d3_a, d3_wd, d3_rd;
    logic [3:0]  d0_we, d0_re, d3_we, d3_re;
    logic        d0_vld, d0_busy, d0_err, d3_vld, d3_busy, d3_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl0 [1024];
    logic [31:0] mdl3 [64];

    logic        exp0_vld = 1'b0;
    logic [31:0] exp0_rd  = '0;
    logic        exp0_err = 1'b0;

    u_lsu #(.DEPTH(1024), .WAIT(0)) u_dut0 (
        .clk(clk), .rstn(rstn0), .lsu_a(d0_a), .lsu_we(d0_we), .lsu_wd(d0_wd),
        .lsu_re(d0_re), .lsu_vld(d0_vld), .lsu_rd(d0_rd), .lsu_busy(d0_busy), .lsu_err(d0_err)
    );

    u_lsu #(.DEPTH(64), .WAIT(3)) u_dut3 (
        .clk(clk), .rstn(rstn3), .lsu_a(d3_a), .lsu_we(d3_we), .lsu_wd(d3_wd),
        .lsu_re(d3_re), .lsu_vld(d3_vld), .lsu_rd(d3_rd), .lsu_busy(d3_busy), .lsu_err(d3_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: word = (address / 4) mod depth, byte-lane write, masked read.
    task automatic mdl_acc(input int dut, input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input logic [3:0] re,
                           output logic [31:0] rd, output logic err);
        int          depth;
        int          w;
        logic [31:0] cur;
        depth = (dut == 0) ? 1024 : 64;
        w     = int'((a / 32'd4) % 32'(depth));
        cur   = (dut == 0) ? mdl0[w] : mdl3[w];
        rd    = '0;
        err   = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
        err = (a % 32'd4) != 0;
`endif
        if (!err) begin
            if (we != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
                if (dut == 0) mdl0[w] = cur;
                else          mdl3[w] = cur;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (re[b]) rd[8*b +: 8] = cur[8*b +: 8];
            end
        end
    endtask

    // One cycle on the zero-wait instance; outputs checked reflect the previous cycle's request.
    task automatic step0(input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] wd, input logic [3:0] re);
        logic        ev;
        logic [31:0] er;
        logic        ee;
        d0_a = a; d0_we = we; d0_wd = wd; d0_re = re;
        ev = (we != 4'd0) || (re != 4'd0);
        er = '0;
        ee = 1'b0;
        if (ev) mdl_acc(0, a, we, wd, re, er, ee);
        @(negedge clk);
        chk("d0_busy", 32'(d0_busy), 32'd0);
        chk("d0_vld", 32'(d0_vld), 32'(exp0_vld));
        chk("d0_rd", d0_rd, exp0_rd);
        if (exp0_vld) chk("d0_err", 32'(d0_err), 32'(exp0_err));
        exp0_vld = ev;
        exp0_rd  = er;
        exp0_err = ee;
        @(posedge clk); #1;
    endtask

    // Full transaction on the WAIT=3 instance, scribbling on the inputs once accepted.
    task automatic txn3(input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [3:0] re);
        logic [31:0] er;
        logic        ee;
        d3_a = a; d3_we = we; d3_wd = wd; d3_re = re;
        mdl_acc(3, a, we, wd, re, er, ee);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk(k < 3 ? "d3_busy_hold" : "d3_busy_release", 32'(d3_busy), (k < 3) ? 32'd1 : 32'd0);
            chk("d3_vld_early", 32'(d3_vld), 32'd0);
            chk("d3_rd_idle", d3_rd, 32'd0);
            @(posedge clk); #1;
            if (k < 3) begin
                d3_a = $urandom; d3_wd = $urandom;
                d3_we = 4'($urandom); d3_re = 4'($urandom);
            end else begin
                d3_a = '0; d3_we = BE_NONE; d3_wd = '0; d3_re = BE_NONE;
            end
        end
        @(negedge clk);
        chk("d3_busy_done", 32'(d3_busy), 32'd0);
        chk("d3_vld", 32'(d3_vld), 32'd1);
        chk("d3_rd", d3_rd, er);
        chk("d3_err", 32'(d3_err), 32'(ee));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        int          kind;
        logic [3:0]  we, re;

        rstn0 = 1'b0; rstn3 = 1'b0;
        d0_a = '0; d0_we = BE_NONE; d0_wd = '0; d0_re = BE_NONE;
        d3_a = '0; d3_we = BE_NONE; d3_wd = '0; d3_re = BE_NONE;
        repeat (2) @(posedge clk);
        #1;
        d3_a = 32'h4; d3_we = BE_WORD; d3_wd = 32'h1234_5678;
        @(negedge clk);
        chk("rst_d0_vld", 32'(d0_vld), 32'd0);
        chk("rst_d0_rd", d0_rd, 32'd0);
        chk("rst_d0_err", 32'(d0_err), 32'd0);
        chk("rst_d0_busy", 32'(d0_busy), 32'd0);
        chk("rst_d3_vld", 32'(d3_vld), 32'd0);
        chk("rst_d3_rd", d3_rd, 32'd0);
        chk("rst_d3_err", 32'(d3_err), 32'd0);
        chk("rst_d3_busy_req", 32'(d3_busy), 32'd0);
        @(posedge clk); #1;
        d3_we = BE_NONE; d3_wd = '0; d3_a = '0;
        rstn0 = 1'b1; rstn3 = 1'b1;

        // Zero-wait instance: fill, directed cases, then random back-to-back traffic.
        for (int i = 0; i < 1024; i++) step0(32'(i * 4), BE_WORD, $urandom, BE_NONE);
        step0(32'h10, BE_WORD, 32'hDEAD_BEEF, BE_NONE);
        step0(32'h10, BE_NONE, 32'h0, BE_WORD);
        step0(32'h20, BE_WORD, 32'h1122_3344, BE_NONE);
        step0(32'h20, 4'b0010, 32'h0000_AA00, BE_NONE);
        step0(32'h20, BE_NONE, 32'h0, BE_WORD);
        step0(32'h20, BE_NONE, 32'h0, 4'b0011);
        step0(32'h1000, BE_WORD, 32'h5, BE_NONE);
        step0(32'h0, BE_NONE, 32'h0, BE_WORD);
        step0(32'h22, BE_WORD, 32'hCAFE_F00D, BE_NONE);
        step0(32'h20, BE_NONE, 32'h0, BE_WORD);
        step0(32'h40, 4'b1001, 32'hA5A5_A5A5, 4'b0110);
        step0(32'h40, BE_NONE, 32'h0, BE_WORD);
        step0(32'h0, BE_NONE, 32'h0, BE_NONE);
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 3);
            we = (kind == 1 || kind == 3) ? 4'($urandom_range(1, 15)) : BE_NONE;
            re = (kind == 2 || kind == 3) ? 4'($urandom_range(1, 15)) : BE_NONE;
            step0(rnd_addr(), we, $urandom, re);
        end
        step0(32'h0, BE_NONE, 32'h0, BE_NONE);
        step0(32'h0, BE_NONE, 32'h0, BE_NONE);

        // Three-wait instance: fill, directed timing, reset abort, random traffic.
        for (int i = 0; i < 64; i++) txn3(32'(i * 4), BE_WORD, $urandom, BE_NONE);
        txn3(32'h10, BE_NONE, 32'h0, BE_WORD);
        txn3(32'h104, 4'b0100, 32'h00EE_0000, BE_NONE);
        txn3(32'h4, BE_NONE, 32'h0, 4'b1100);

        old = mdl3[2];
        d3_a = 32'h8; d3_we = BE_WORD; d3_wd = ~old; d3_re = BE_NONE;
        @(negedge clk);
        chk("abort_busy_accept", 32'(d3_busy), 32'd1);
        @(posedge clk); #1;
        rstn3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_busy", 32'(d3_busy), 32'd0);
            chk("abort_vld", 32'(d3_vld), 32'd0);
            chk("abort_rd", d3_rd, 32'd0);
            @(posedge clk); #1;
            if (k == 1) begin
                d3_a = '0; d3_we = BE_NONE; d3_wd = '0;
                rstn3 = 1'b1;
            end
        end
        txn3(32'h8, BE_NONE, 32'h0, BE_WORD);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(1, 3);
            we = (kind == 1 || kind == 3) ? 4'($urandom_range(1, 15)) : BE_NONE;
            re = (kind == 2 || kind == 3) ? 4'($urandom_range(1, 15)) : BE_NONE;
            txn3(rnd_addr(), we, $urandom, re);
        end
        @(negedge clk);
        chk("d3_vld_single", 32'(d3_vld), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/u_lsu.md
U_LSU -- requirements
Module: u_lsu

Interface
REQ-001 Parameter: DEPTH, default 1024, data-RAM size in 32-bit words (power of two).
REQ-002 Parameter: WAIT, default 0, wait states added per access (0..15).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 lsu_a  in  32  byte address from execute stage.
REQ-006 lsu_we  in  4  write byte enables; nonzero = write request.
REQ-007 lsu_wd  in  32  write data, byte lanes aligned to lsu_we.
REQ-008 lsu_re  in  4  read byte enables; nonzero = read request.
REQ-009 lsu_vld  out  1  completion pulse, one cycle per accepted request.
REQ-010 lsu_rd  out  32  read data, valid while lsu_vld=1.
REQ-011 lsu_busy  out  1  stall to hazard unit; requester SHALL hold lsu_* stable while 1.
REQ-012 lsu_err  out  1  misaligned-access flag, qualified by lsu_vld.

Function
REQ-013 Request present when |lsu_we or |lsu_re; accepted only in state IDLE.
REQ-014 States: IDLE, BUSY; IDLE->BUSY on accepted request when WAIT>0; BUSY->IDLE after WAIT cycles; IDLE->IDLE when WAIT=0.
REQ-015 Request accepted in cycle T: lsu_busy=1 in cycles T..T+WAIT-1, 0 in T+WAIT; lsu_busy always 0 when WAIT=0.
REQ-016 RAM access performed at clock edge ending cycle T+WAIT; lsu_vld=1 exactly in cycle T+WAIT+1.
REQ-017 WAIT=0: back-to-back requests accepted every cycle, one lsu_vld per request, order preserved.
REQ-018 Request captured at accept; input changes during BUSY ignored.
REQ-019 Word index = lsu_a[log2(DEPTH)+1:2]; upper address bits ignored (wrap modulo DEPTH).
REQ-020 Write: only lanes with lsu_we[i]=1 updated; other bytes unchanged; lsu_rd=0 on write completion.
REQ-021 Read: lsu_rd byte i = RAM byte i if lsu_re[i]=1, else 0.
REQ-022 lsu_we and lsu_re both nonzero: treated as write; lsu_re ignored.
REQ-023 Read to a word written by the immediately preceding request returns the new data.
REQ-024 lsu_vld=0 and lsu_rd held at 0 in all cycles without completion.

Reset
REQ-025 rstn=0 at a clock edge: state IDLE, wait counter 0, lsu_vld=0, lsu_rd=0, lsu_err=0; lsu_busy=0 while rstn=0.
REQ-026 Reset mid-BUSY: pending access discarded, no RAM write, no lsu_vld.
REQ-027 RAM contents not reset.

Configuration
REQ-028 Macro LSU_MISALIGN_CHK_EN defined: request with lsu_a[1:0]!=0 completes with lsu_err=1, write suppressed, lsu_rd=0, same timing.
REQ-029 Macro undefined: lsu_a[1:0] ignored, lsu_err tied 0.

Structure
REQ-030 Shared package lsu_pkg: state enum, byte-enable constants (BE_NONE=4'b0000, BE_WORD=4'b1111), WAIT max constant.
REQ-031 One sub-module u_dmem: DEPTH-word byte-lane-writable synchronous RAM, one read/write port.
REQ-032 FSM, wait counter, request capture, response registers in u_lsu.

Verification
REQ-033 WAIT=0: write 0xDEADBEEF to 0x10 with we=1111, then read 0x10 re=1111 -> vld next cycle, rd=0xDEADBEEF, busy never 1.
REQ-034 Byte lanes: word 0x20=0x11223344, write we=0010 wd=0x0000AA00, read re=1111 -> rd=0x1122AA44; read re=0011 -> rd=0x0000AA44.
REQ-035 WAIT=3: read accepted cycle T -> busy=1 in T..T+2, 0 in T+3, vld=1 only in T+4.
REQ-036 Wrap: DEPTH=1024, write 0x5 to 0x1000, read 0x0 -> rd=0x5.
REQ-037 WAIT=3: rstn=0 in cycle T+1 after write accept -> no vld, subsequent read shows old data.
REQ-038 LSU_MISALIGN_CHK_EN: write we=1111 to 0x22 -> vld=1 with err=1, word 0x20 unchanged; macro off -> err=0, word 0x20 written.
